// File: rtl/pipeline_control_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// State encodings are fixed so they stay stable for debug visibility.
package pipeline_control_pkg;

  localparam int DEFAULT_PIPELINE_CONTROL_COUNTER_SIZE = 16;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pipeline_control_if.sv
// Hazard/debug inputs and stage-enable outputs of the pipeline controller.
// master drives the ID/EX/WB status and debug commands; slave is the controller.
interface pipeline_control_if #(
  parameter int COUNTER_SIZE = 16
);

  logic                    i_enable;
  logic                    i_step;
  logic [4:0]              i_id_rs;
  logic [4:0]              i_id_rt;
  logic [4:0]              i_ex_rt;
  logic                    i_ex_mem_rd;
  logic                    i_id_jump_taken;
  logic                    i_id_halt;
  logic                    i_wb_halt;

  logic                    o_pipeline_en;
  logic                    o_pc_write;
  logic                    o_if_id_write;
  logic                    o_if_id_flush;
  logic                    o_id_ex_bubble;
  logic                    o_halted;
  logic [COUNTER_SIZE-1:0] o_stall_count;
  logic [COUNTER_SIZE-1:0] o_flush_count;
  logic [COUNTER_SIZE-1:0] o_cycle_count;

  modport master (
    output i_enable, i_step, i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_rd,
           i_id_jump_taken, i_id_halt, i_wb_halt,
    input  o_pipeline_en, o_pc_write, o_if_id_write, o_if_id_flush,
           o_id_ex_bubble, o_halted, o_stall_count, o_flush_count, o_cycle_count
  );

  modport slave (
    input  i_enable, i_step, i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_rd,
           i_id_jump_taken, i_id_halt, i_wb_halt,
    output o_pipeline_en, o_pc_write, o_if_id_write, o_if_id_flush,
           o_id_ex_bubble, o_halted, o_stall_count, o_flush_count, o_cycle_count
  );

endinterface

// File: rtl/pipeline_control_load_use_detector.sv
// Flags a load in EX whose destination feeds the instruction in ID;
// forwarding cannot cover this, so one stall cycle is needed. r0 never hazards.
module load_use_detector (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_rd,
  output logic       lu
);

  assign lu = ex_mem_rd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_control.sv
// Advance/stall/flush sequencing for the five-stage pipeline, incl. halt drain.
// Optional performance counters: define PIPELINE_CONTROL_PERF_COUNTERS_EN.
//
// state  | meaning
// RUN    | normal execution
// DRAIN  | HALT accepted, fetch stopped while the pipeline empties
// HALTED | terminal, left only by reset
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int COUNTER_SIZE = DEFAULT_PIPELINE_CONTROL_COUNTER_SIZE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pipeline_control_if.slave  ctl
);

  pc_state_e state_q, state_d;
  logic      lu;
  logic      adv;

  load_use_detector u_load_use_detector (
    .id_rs     (ctl.i_id_rs),
    .id_rt     (ctl.i_id_rt),
    .ex_rt     (ctl.i_ex_rt),
    .ex_mem_rd (ctl.i_ex_mem_rd),
    .lu        (lu)
  );

  // Reset is folded in here so every control output reads 0 while it is held.
  assign adv = !i_reset && (state_q != HALTED) && (ctl.i_enable || ctl.i_step);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    ctl.o_pipeline_en  = adv;
    ctl.o_pc_write     = 1'b0;
    ctl.o_if_id_write  = 1'b0;
    ctl.o_if_id_flush  = 1'b0;
    ctl.o_id_ex_bubble = 1'b0;
    ctl.o_halted       = !i_reset && (state_q == HALTED);
    if (adv) begin
      case (state_q)
        RUN: begin
          if (lu) begin
            ctl.o_id_ex_bubble = 1'b1;
          end else if (ctl.i_id_halt) begin
            ctl.o_if_id_flush = 1'b1;
            state_d           = DRAIN;
          end else if (ctl.i_id_jump_taken) begin
            ctl.o_pc_write    = 1'b1;
            ctl.o_if_id_flush = 1'b1;
          end else begin
            ctl.o_pc_write    = 1'b1;
            ctl.o_if_id_write = 1'b1;
          end
        end
        DRAIN: begin
          ctl.o_if_id_flush = 1'b1;
          if (ctl.i_wb_halt) state_d = HALTED;
        end
        default: ;
      endcase
    end
  end

`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

  logic [COUNTER_SIZE-1:0] stall_q, flush_q, cycle_q;
  logic                    stall_inc, flush_inc, cycle_inc;

  // Halt-drain flushes are deliberately not counted as jump flushes.
  assign stall_inc = adv && (state_q == RUN) && lu;
  assign flush_inc = adv && (state_q == RUN) && !lu && !ctl.i_id_halt && ctl.i_id_jump_taken;
  assign cycle_inc = adv && ((state_q == RUN) || (state_q == DRAIN));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_q <= '0;
      flush_q <= '0;
      cycle_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
      if (cycle_inc && (cycle_q != '1)) cycle_q <= cycle_q + CNT_ONE;
    end
  end

  assign ctl.o_stall_count = i_reset ? '0 : stall_q;
  assign ctl.o_flush_count = i_reset ? '0 : flush_q;
  assign ctl.o_cycle_count = i_reset ? '0 : cycle_q;
`else
  assign ctl.o_stall_count = '0;
  assign ctl.o_flush_count = '0;
  assign ctl.o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: each cycle's expected control vector
// is queued as the stimulus is driven and popped when the outputs are sampled.
module tb_pipeline_control;

  localparam int CW = 4;
`ifdef PIPELINE_CONTROL_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pipeline_en, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted}
  localparam logic [5:0] E_RUN   = 6'b111000;
  localparam logic [5:0] E_STALL = 6'b100010;
  localparam logic [5:0] E_JMP   = 6'b110100;
  localparam logic [5:0] E_DRN   = 6'b100100;
  localparam logic [5:0] E_HLT   = 6'b000001;
  localparam logic [5:0] E_OFF   = 6'b000000;

  typedef struct packed {
    logic       rst, en, step, mrd;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       jmp, hlt, wbh;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [5:0] e;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_control_if #(.COUNTER_SIZE(CW)) bus ();

  pipeline_control #(.COUNTER_SIZE(CW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ctl     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [5:0]  exp_q[$];
  step_t       plan[$];
  logic [5:0]  got, want;
  logic [3*CW-1:0] got_c, want_c;

  function automatic stim_t mk(logic r, logic e, logic st, logic m, logic [4:0] ex,
                               logic [4:0] rs, logic [4:0] rt, logic j, logic h, logic w);
    stim_t s;
    s.rst = r; s.en = e; s.step = st; s.mrd = m;
    s.ex_rt = ex; s.id_rs = rs; s.id_rt = rt;
    s.jmp = j; s.hlt = h; s.wbh = w;
    return s;
  endfunction

  function automatic logic [5:0] obs();
    return {bus.o_pipeline_en, bus.o_pc_write, bus.o_if_id_write,
            bus.o_if_id_flush, bus.o_id_ex_bubble, bus.o_halted};
  endfunction

  function automatic logic [3*CW-1:0] cnts();
    return {bus.o_stall_count, bus.o_flush_count, bus.o_cycle_count};
  endfunction

  function automatic logic [3*CW-1:0] cexp(int stall, int flush, int cyc);
    logic [CW-1:0] a, b, c;
    a = CW'(stall); b = CW'(flush); c = CW'(cyc);
    return PERF ? {a, b, c} : '0;
  endfunction

  task automatic drive(input stim_t s);
    rst                 = s.rst;
    bus.i_enable        = s.en;
    bus.i_step          = s.step;
    bus.i_ex_mem_rd     = s.mrd;
    bus.i_ex_rt         = s.ex_rt;
    bus.i_id_rs         = s.id_rs;
    bus.i_id_rt         = s.id_rt;
    bus.i_id_jump_taken = s.jmp;
    bus.i_id_halt       = s.hlt;
    bus.i_wb_halt       = s.wbh;
  endtask

  task automatic add(input stim_t s, input logic [5:0] e);
    step_t p;
    p.s = s; p.e = e;
    plan.push_back(p);
  endtask

  stim_t RST_S, NOP_S, IDLE_S, STEP_S;

  task automatic test_reset();
    plan.delete();
    add(RST_S, E_OFF);
    add(NOP_S, E_RUN);
    add(mk(0,1,0,0,0,0,0,0,1,0), E_DRN);
    add(NOP_S, E_DRN);
    add(RST_S, E_OFF);
    add(NOP_S, E_RUN);
    add(NOP_S, E_RUN);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(0, 0, 2); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL reset counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    plan.delete();
    add(RST_S, E_OFF);
    add(mk(0,1,0,1,5,0,5,0,0,0), E_STALL);
    add(NOP_S, E_RUN);
    add(mk(0,1,0,1,0,0,0,0,0,0), E_RUN);
    add(mk(0,1,0,1,7,7,3,0,0,0), E_STALL);
    add(mk(0,1,0,0,7,7,3,0,0,0), E_RUN);
    add(mk(0,1,0,1,6,5,4,0,0,0), E_RUN);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL load_use[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(2, 0, 6); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL load_use counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jump();
    plan.delete();
    add(RST_S, E_OFF);
    add(mk(0,1,0,0,0,0,0,1,0,0), E_JMP);
    add(mk(0,1,0,1,3,3,0,1,0,0), E_STALL);
    add(mk(0,1,0,0,0,0,0,1,0,0), E_JMP);
    add(mk(0,1,0,1,9,0,9,0,1,0), E_STALL);
    add(NOP_S, E_RUN);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL jump[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(2, 2, 5); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL jump counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    plan.delete();
    add(RST_S, E_OFF);
    add(NOP_S, E_RUN);
    add(mk(0,1,0,0,0,0,0,0,0,1), E_RUN);
    add(mk(0,1,0,0,0,0,0,0,1,0), E_DRN);
    add(mk(0,1,0,0,0,0,0,1,0,0), E_DRN);
    add(mk(0,1,0,1,4,4,0,0,0,0), E_DRN);
    add(mk(0,1,0,0,0,0,0,0,0,1), E_DRN);
    add(NOP_S, E_HLT);
    add(mk(0,1,1,0,0,0,0,1,1,1), E_HLT);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL halt[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(0, 0, 6); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL halt counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  // Entered with the DUT halted and nonzero cycle count from test_halt.
  task automatic test_reset_from_halt();
    drive(RST_S); exp_q.push_back(E_OFF);
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL rst_halt ctrl_during got %b want %b", got, want);
    end
    got_c = cnts(); n_tests++;
    if (got_c !== '0) begin
      n_fail++; $display("FAIL rst_halt counters_during got %h want 0", got_c);
    end
    @(posedge clk); #1;
    drive(NOP_S); exp_q.push_back(E_RUN);
    @(negedge clk);
    got = obs(); want = exp_q.pop_front(); n_tests++;
    if (got !== want) begin
      n_fail++; $display("FAIL rst_halt ctrl_after got %b want %b", got, want);
    end
    got_c = cnts(); n_tests++;
    if (got_c !== '0) begin
      n_fail++; $display("FAIL rst_halt counters_after got %h want 0", got_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_step();
    plan.delete();
    add(RST_S, E_OFF);
    add(IDLE_S, E_OFF);
    add(STEP_S, E_RUN);
    add(IDLE_S, E_OFF);
    add(IDLE_S, E_OFF);
    add(STEP_S, E_RUN);
    add(IDLE_S, E_OFF);
    add(STEP_S, E_RUN);
    add(mk(0,0,0,1,2,2,0,1,1,0), E_OFF);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL step[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(0, 0, 3); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL step counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    plan.delete();
    add(RST_S, E_OFF);
    for (int k = 0; k < 20; k++) add(NOP_S, E_RUN);
    foreach (plan[i]) begin
      drive(plan[i].s); exp_q.push_back(plan[i].e);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL saturation[%0d] ctrl got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    drive(IDLE_S); @(negedge clk);
    got_c = cnts(); want_c = cexp(0, 0, 15); n_tests++;
    if (got_c !== want_c) begin
      n_fail++; $display("FAIL saturation counters got %h want %h", got_c, want_c);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    RST_S  = mk(1,1,0,0,0,0,0,0,0,0);
    NOP_S  = mk(0,1,0,0,0,0,0,0,0,0);
    IDLE_S = mk(0,0,0,0,0,0,0,0,0,0);
    STEP_S = mk(0,0,1,0,0,0,0,0,0,0);
    drive(RST_S);
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_jump();
    test_halt();
    test_reset_from_halt();
    test_step();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
